// File: rtl/adc_word_align.sv
// Word aligner for a 6-bit DDR deserializer: bitslips until the ADC training
// pattern is found, resolves the hi/lo word phase, then assembles 12-bit samples.
module adc_word_align #(
    parameter logic [5:0]  PAT_HI    = 6'h28,
    parameter logic [5:0]  PAT_LO    = 6'h3C,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned CHECK_LEN = 8,
    parameter int unsigned MAX_SLIP  = 12
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [5:0]  DIN,
    input  logic        train,
    output logic        BS,
    output logic        locked,
    output logic        fail,
    output logic [3:0]  slip_cnt,
    output logic [11:0] sample,
    output logic        sample_valid
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_CHECK  = 3'd2,
        S_SLIP   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [8:0] MATCH_LAST  = 9'(2 * CHECK_LEN - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIP);

    state_t      state_r, state_s;
    logic [3:0]  settle_r, settle_s;
    logic [8:0]  match_r, match_s;
    logic        expect_hi_r, expect_hi_s;
    logic [3:0]  slip_r, slip_s;
    logic        phase_r, phase_s;
    logic [5:0]  hi_r, hi_s;
    logic [11:0] sample_r, sample_s;
    logic        sv_r, sv_s;
    logic        bs_r, locked_r, fail_r;
    logic        word_ok_s;

    // Next-state and next-datapath logic; train overrides every state.
    always_comb begin
        state_s     = state_r;
        settle_s    = settle_r;
        match_s     = match_r;
        expect_hi_s = expect_hi_r;
        slip_s      = slip_r;
        phase_s     = phase_r;
        hi_s        = hi_r;
        sample_s    = sample_r;
        sv_s        = 1'b0;
        word_ok_s   = 1'b0;
        if (train) begin
            state_s  = S_WAIT;
            settle_s = 4'd0;
            match_s  = 9'd0;
            slip_s   = 4'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_IDLE;
                end
                S_WAIT: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_s  = S_CHECK;
                        settle_s = 4'd0;
                        match_s  = 9'd0;
                    end else begin
                        settle_s = settle_r + 4'd1;
                    end
                end
                S_CHECK: begin
                    // The first word picks the word phase; later words must alternate.
                    if (match_r == 9'd0) begin
                        if (DIN == PAT_HI) begin
                            word_ok_s   = 1'b1;
                            expect_hi_s = 1'b0;
                        end else if (DIN == PAT_LO) begin
                            word_ok_s   = 1'b1;
                            expect_hi_s = 1'b1;
                        end else begin
                            word_ok_s   = 1'b0;
                        end
                    end else if (DIN == (expect_hi_r ? PAT_HI : PAT_LO)) begin
                        word_ok_s   = 1'b1;
                        expect_hi_s = ~expect_hi_r;
                    end else begin
                        word_ok_s   = 1'b0;
                    end

                    if (!word_ok_s) begin
                        state_s = (slip_r >= SLIP_MAX) ? S_FAIL : S_SLIP;
                    end else if ((match_r >= MATCH_LAST) && (DIN == PAT_LO)) begin
                        state_s = S_LOCKED;
                        phase_s = 1'b0;
                    end else begin
                        match_s = match_r + 9'd1;
                    end
                end
                S_SLIP: begin
                    state_s  = S_WAIT;
                    settle_s = 4'd0;
                    slip_s   = (slip_r == 4'hF) ? slip_r : slip_r + 4'd1;
                end
                S_LOCKED: begin
                    if (!phase_r) begin
                        hi_s    = DIN;
                        phase_s = 1'b1;
                    end else begin
                        sample_s = {hi_r, DIN};
                        sv_s     = 1'b1;
                        phase_s  = 1'b0;
                    end
                end
                S_FAIL: begin
                    state_s = S_FAIL;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, capture registers and registered outputs decoded from the next state.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            settle_r    <= 4'd0;
            match_r     <= 9'd0;
            expect_hi_r <= 1'b0;
            slip_r      <= 4'd0;
            phase_r     <= 1'b0;
            hi_r        <= 6'd0;
            sample_r    <= 12'd0;
            sv_r        <= 1'b0;
            bs_r        <= 1'b0;
            locked_r    <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            settle_r    <= settle_s;
            match_r     <= match_s;
            expect_hi_r <= expect_hi_s;
            slip_r      <= slip_s;
            phase_r     <= phase_s;
            hi_r        <= hi_s;
            sample_r    <= sample_s;
            sv_r        <= sv_s;
            bs_r        <= (state_s == S_SLIP);
            locked_r    <= (state_s == S_LOCKED);
            fail_r      <= (state_s == S_FAIL);
        end
    end

    assign BS           = bs_r;
    assign locked       = locked_r;
    assign fail         = fail_r;
    assign slip_cnt     = slip_r;
    assign sample       = sample_r;
    assign sample_valid = sv_r;

endmodule

// File: tb/tb_adc_word_align.sv
// Scoreboard bench for adc_word_align: a rotating-stream deserializer model drives
// DIN, expected samples are queued from the driven words and popped by a monitor.
module tb_adc_word_align;
    localparam int          SETTLE = 4;
    localparam logic [11:0] PAT12  = 12'hA3C;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        train = 1'b0;
    logic [5:0]  DIN = 6'd0;
    logic        BS, locked, fail, sample_valid;
    logic [3:0]  slip_cnt;
    logic [11:0] sample;

    adc_word_align dut (
        .CLK(CLK), .reset(reset), .DIN(DIN), .train(train),
        .BS(BS), .locked(locked), .fail(fail), .slip_cnt(slip_cnt),
        .sample(sample), .sample_valid(sample_valid)
    );

    typedef struct {
        logic [11:0] val;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mode = 0;      // 0 pattern stream, 1 zeros, 2 pairs 01/02, 3 random
    int          pos = 0;       // bit offset of the next word in the 12-bit stream
    int          bs_count = 0;
    int          last_bs = -100;
    int          t0 = 0;
    logic [11:0] last_sample = 12'd0;
    logic [23:0] dbl;
    logic [5:0]  w, hi_w;
    bit          bs_d1 = 1'b0, bs_d2 = 1'b0, track = 1'b0, bs_prev = 1'b0;
    int          k = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            #5 CLK = 1'b1;
            cyc++;
            #5 CLK = 1'b0;
        end
    end

    // Deserializer model and scoreboard producer.
    initial begin
        dbl = {PAT12, PAT12};
        forever begin
            @(negedge CLK);
            bs_d2 = bs_d1;
            bs_d1 = BS;
            if (bs_d2) pos = (pos + 1) % 12;
            if (!locked || train) begin
                track = 1'b0;
                k = 0;
            end else if (!track) begin
                track = 1'b1;
                k = 0;
            end else begin
                k++;
            end
            case (mode)
                0: begin
                    w = dbl[23-pos -: 6];
                    pos = (pos + 6) % 12;
                end
                1: w = 6'h00;
                2: w = (k % 2 == 0) ? 6'h01 : 6'h02;
                default: w = 6'($urandom_range(0, 63));
            endcase
            DIN = w;
            if (track) begin
                if (k % 2 == 0) begin
                    hi_w = w;
                end else begin
                    exp_q.push_back('{val: {hi_w, w}, at: cyc + 1});
                end
            end
        end
    end

    // Monitor: sample scoreboard, hold behaviour and bitslip pulse shape.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (BS) begin
                check("bs_single_cycle", int'(bs_prev), 0);
                check("bs_spacing", int'(cyc - last_bs >= SETTLE + 1), 1);
                bs_count++;
                last_bs = cyc;
            end
            bs_prev = BS;
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("sample_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_value", sample, e.val);
                    check("sample_latency", cyc, e.at);
                end
                last_sample = sample;
            end else if (!reset) begin
                last_sample = 12'd0;
            end else if (locked) begin
                check("sample_hold", sample, last_sample);
            end
        end
    end

    task automatic pulse_train(input int p);
        @(posedge CLK);
        #1;
        if (p >= 0) pos = p;
        train = 1'b1;
        t0 = cyc;
        @(posedge CLK);
        #1;
        train = 1'b0;
    endtask

    task automatic wait_lock(input string name, input int budget, output int lat);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (locked || fail) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check({name, "_timeout"}, 0, 1);
        lat = cyc - t0 - 1;
    endtask

    initial begin
        int lat, bs0, p, strobes;
        #12;
        check("rst_bs", BS, 0);
        check("rst_locked", locked, 0);
        check("rst_fail", fail, 0);
        check("rst_slip_cnt", slip_cnt, 0);
        check("rst_sample", sample, 0);
        check("rst_sample_valid", sample_valid, 0);
        @(posedge CLK);
        #1 reset = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_locked", locked, 0);
        check("idle_bs", bs_count, 0);

        // T1: aligned, first checked word is the high half.
        bs0 = bs_count;
        mode = 0;
        pulse_train(6);
        wait_lock("t1", 200, lat);
        check("t1_lock_latency", lat, SETTLE + 16);
        check("t1_slip_cnt", slip_cnt, 0);
        check("t1_bs_pulses", bs_count - bs0, 0);
        repeat (10) @(negedge CLK);
        check("t1_sample", sample, 12'hA3C);

        // T5: data pairs 01/02, then random data, then a train mid-stream.
        @(posedge CLK);
        #1 mode = 2;
        repeat (6) @(negedge CLK);
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (sample_valid) strobes++;
        end
        check("t5_strobe_rate", strobes, 4);
        check("t5_sample", sample, 12'h042);
        @(posedge CLK);
        #1 mode = 3;
        repeat (30) @(negedge CLK);
        @(posedge CLK);
        #1 train = 1'b1;
        mode = 0;
        t0 = cyc;
        @(posedge CLK);
        #1 train = 1'b0;
        check("t5_train_drops_locked", locked, 0);
        check("t5_train_drops_valid", sample_valid, 0);
        wait_lock("t5_relock", 300, lat);
        check("t5_relocked", locked, 1);

        // T2: aligned, word phase starts on the low half.
        repeat (10) @(negedge CLK);
        bs0 = bs_count;
        pulse_train(0);
        wait_lock("t2", 200, lat);
        check("t2_lock_latency", lat, SETTLE + 17);
        check("t2_slip_cnt", slip_cnt, 0);
        check("t2_bs_pulses", bs_count - bs0, 0);
        repeat (10) @(negedge CLK);
        check("t2_sample", sample, 12'hA3C);

        // T3: misaligned by 3 bits.
        bs0 = bs_count;
        pulse_train(3);
        wait_lock("t3", 300, lat);
        check("t3_locked", locked, 1);
        check("t3_slip_cnt", slip_cnt, 3);
        check("t3_bs_pulses", bs_count - bs0, 3);
        repeat (10) @(negedge CLK);
        check("t3_sample", sample, 12'hA3C);

        // Random starting offsets: slips needed to reach a word boundary.
        for (int it = 0; it < 4; it++) begin
            p = $urandom_range(0, 11);
            bs0 = bs_count;
            pulse_train(p);
            wait_lock("rnd", 300, lat);
            check("rnd_locked", locked, 1);
            check("rnd_slip_cnt", slip_cnt, (6 - p % 6) % 6);
            check("rnd_bs_pulses", bs_count - bs0, (6 - p % 6) % 6);
            repeat (8) @(negedge CLK);
        end

        // T4: constant zeros, alignment gives up.
        bs0 = bs_count;
        @(posedge CLK);
        #1 mode = 1;
        pulse_train(-1);
        wait_lock("t4", 500, lat);
        check("t4_fail", fail, 1);
        check("t4_locked", locked, 0);
        check("t4_slip_cnt", slip_cnt, 12);
        check("t4_bs_pulses", bs_count - bs0, 12);
        repeat (40) @(negedge CLK);
        check("t4_no_more_bs", bs_count - bs0, 12);
        check("t4_fail_held", fail, 1);

        // T6: asynchronous reset during CHECK after two slips.
        bs0 = bs_count;
        pulse_train(-1);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bs_count - bs0 >= 2) break;
        end
        check("t6_two_slips_seen", bs_count - bs0, 2);
        repeat (5) @(posedge CLK);
        #2;
        check("t6_pre_slip_cnt", slip_cnt, 2);
        reset = 1'b0;
        #1;
        check("t6_bs", BS, 0);
        check("t6_locked", locked, 0);
        check("t6_fail", fail, 0);
        check("t6_slip_cnt", slip_cnt, 0);
        check("t6_sample", sample, 0);
        check("t6_sample_valid", sample_valid, 0);
        @(posedge CLK);
        #1 reset = 1'b1;
        repeat (20) @(negedge CLK);
        check("t6_idle_bs", bs_count - bs0, 2);
        check("t6_idle_fail", fail, 0);
        check("t6_idle_slip_cnt", slip_cnt, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
